irrigation_scheduler: RTL and testbench
=======================================

# irrigation_scheduler

Time-of-day scheduler that drives the control inputs of the smart irrigation controller. It runs on the 1 Hz clock, keeps hour-of-day, and issues `auto_cycle_start` at a programmed start hour, retrying while it rains. At midnight it clears each zone's usage and reloads its daily quota through the controller's `reset_user`, `quota_wr`, `quota_set` and zone-select port. It sits upstream of the controller and watches `sequencer_active` to know when an automatic cycle is running and when it has finished.

## Interface
- NUM_USERS, 4, number of zones (2..4; the zone index is 2 bits)
- WIDTH, 6, quota width; matches the controller
- SEC_PER_HOUR, 3600, 1 Hz ticks per hour (benches use 4)
- START_HOUR, 6, hour at which the daily automatic cycle is attempted (0..23)
- RETRY_HOURS, 2, extra hourly attempts after START_HOUR when a start is skipped for rain
- ACK_TIMEOUT, 2, clk_1hz cycles to wait for `sequencer_active` after a start

Ports:
- clk_1hz  in  1  scheduler clock
- rst_n  in  1  reset; asynchronous, active-low
- time_set  in  1  load hour: `hour <= time_hour`, seconds counter to 0
- time_hour  in  5  hour value to load (0..23; values ≥24 ignored)
- cfg_we  in  1  write the daily quota shadow register
- cfg_addr  in  2  shadow register index
- cfg_data  in  WIDTH  shadow quota value
- rain  in  1  rain sensor, 1 = raining
- sequencer_active  in  1  from the controller
- auto_cycle_start  out  1  start pulse to the controller
- user_select_manual  out  2  zone index used for clears and loads
- reset_user  out  1  clear usage for the selected zone
- quota_wr  out  1  write quota for the selected zone
- quota_set  out  WIDTH  quota value to write
- hour  out  5  current hour
- busy  out  1  state ≠ IDLE
- skipped_rain  out  1  sticky flag: today's start was deferred or abandoned for rain
- start_fail  out  1  sticky flag: the last start got no acknowledge
- cycle_count  out  8  completed automatic cycles, saturating at 255

## Operation
**Timekeeping**
- `sec` counts 0..SEC_PER_HOUR-1.
- `hour_tick` = (`sec` == SEC_PER_HOUR-1). On `hour_tick`, `sec` returns to 0 and `hour` advances 23→0.
- `time_set` has priority over counting. It generates no events and does not clear `done_today`.

**Events on hour_tick**, with h' = the new hour:
- If h' == 0: set `mid_pend` and clear `done_today`.
- If START_HOUR ≤ h' ≤ START_HOUR+RETRY_HOURS (window not wrapping past 23) and `!done_today`: set `start_pend`.

**Shadow registers**
- There are NUM_USERS quota shadow registers.
- `cfg_we` with `cfg_addr` < NUM_USERS writes `cfg_data`; other addresses are ignored.
- A write landing during a load sequence takes effect for zones not yet loaded.

**FSM states:** IDLE, CLR, LOAD, START, ACK, RUN. Zone index `u` is 2 bits.
- **IDLE**, priority order:
  - `mid_pend` && `!sequencer_active` → CLR with `u`=0, clear `mid_pend`.
  - Else `start_pend` && `rain` → clear `start_pend`, set `skipped_rain`, stay in IDLE.
  - Else `start_pend` && `sequencer_active` → clear `start_pend`, set `done_today` (a cycle is already running).
  - Else `start_pend` → START, clear `start_pend`, set `done_today`.
- **CLR:** `reset_user`=1, `user_select_manual`=`u`. → LOAD.
- **LOAD:** `quota_wr`=1, `quota_set`=shadow[`u`], `user_select_manual`=`u`. If `u` == NUM_USERS-1 → IDLE; else `u`+1 → CLR.
- **START:** `auto_cycle_start`=1. → ACK, ack counter cleared.
- **ACK:**
  - `sequencer_active` → RUN, clear `start_fail`, clear `skipped_rain`.
  - Otherwise, after ACK_TIMEOUT cycles in ACK → IDLE with `start_fail`=1.
- **RUN:** `!sequencer_active` → IDLE, `cycle_count`+1 (saturating at 255).

**Deferral and interaction**
- The midnight sequence is deferred while `sequencer_active`=1, because the controller ignores the manual select during a cycle.
- Events arriving while busy stay pending and are served from IDLE.
- With START_HOUR=0, the midnight sequence runs first, then the start.

**Outputs**
- All outputs are registered. Strobes are high for exactly one clk_1hz period.
- The controller samples them level-sensitively on its faster clock, so repeated clears or writes within that period are idempotent.
- `user_select_manual` is 0 outside CLR and LOAD. `quota_set` is 0 outside LOAD.

## Timing
- Reset values:
  - All outputs 0.
  - `sec`, `hour`, `u`, `done_today`, `mid_pend`, `start_pend` all 0.
  - Shadow registers 0. State is IDLE.
  - No midnight event is generated by reset itself.
- Latency from event to action:
  - The `hour_tick` edge sets the pend flag.
  - The FSM acts on the next edge.
  - The strobe is visible one edge after that.
- A full midnight sequence takes 2·NUM_USERS cycles: CLR0, LOAD0, CLR1, … LOAD(N-1).
- Start: 1 cycle in START, then 1..ACK_TIMEOUT cycles in ACK.
- A reset during any state aborts immediately. No strobe may be left high, and a partial midnight load is not resumed.
- `hour_tick` coinciding with `time_set`: `time_set` wins and the tick is dropped.

## Test plan
- **Midnight reload.** SEC_PER_HOUR=4, shadow = {10,20,30,40}, `time_set` with hour 23, run 4 ticks → `hour`=0, then 8 cycles of alternating `reset_user` and `quota_wr` strobes, with `user_select_manual` 0,0,1,1,2,2,3,3 and `quota_set` 10,20,30,40 on the LOAD cycles.
- **Normal start.** Hour reaches 6, `rain`=0, bench raises `sequencer_active` 1 cycle after `auto_cycle_start`, drops it 20 cycles later → exactly one `auto_cycle_start` pulse, RUN for 20 cycles, `cycle_count`=1, `start_fail`=0.
- **Rain retry.** `rain`=1 through hours 6 and 7, `rain`=0 at hour 8 → `skipped_rain` set at hour 6, start issued at hour 8, `skipped_rain` cleared on ack. With rain through hour 8 → no start and `skipped_rain` stays 1.
- **No acknowledge.** `sequencer_active` held 0 → `start_fail`=1 exactly ACK_TIMEOUT cycles after the ACK entry, no second start that day.
- **Deferred midnight.** `sequencer_active`=1 across the 23→0 rollover → no strobes. `sequencer_active` falls → `cycle_count`+1, then the CLR0 strobe 1 cycle after IDLE is entered.
- **Reset mid-LOAD.** Assert `rst_n`=0 during LOAD of zone 1 → all outputs 0 immediately, `hour`=0, no sequence resumes after release.

Source files
------------

// File: rtl/irrigation_scheduler_if.sv
// Control link between the irrigation scheduler (master) and the irrigation controller (slave).
interface irrigation_scheduler_if #(
   parameter int WIDTH = 6
);
   logic             auto_cycle_start;
   logic [1:0]       user_select_manual;
   logic             reset_user;
   logic             quota_wr;
   logic [WIDTH-1:0] quota_set;
   logic             sequencer_active;

   modport master (
      output auto_cycle_start,
      output user_select_manual,
      output reset_user,
      output quota_wr,
      output quota_set,
      input  sequencer_active
   );

   modport slave (
      input  auto_cycle_start,
      input  user_select_manual,
      input  reset_user,
      input  quota_wr,
      input  quota_set,
      output sequencer_active
   );
endinterface

// File: rtl/irrigation_scheduler.sv
// Hour-of-day scheduler: nightly per-zone usage clear and quota reload, plus the daily
// automatic-cycle start with hourly rain retries, driving the irrigation controller.
module irrigation_scheduler #(
   parameter int NUM_USERS    = 4,
   parameter int WIDTH        = 6,
   parameter int SEC_PER_HOUR = 3600,
   parameter int START_HOUR   = 6,
   parameter int RETRY_HOURS  = 2,
   parameter int ACK_TIMEOUT  = 2
) (
   input  logic                   clk_1hz,
   input  logic                   rst_n,
   input  logic                   time_set,
   input  logic [4:0]             time_hour,
   input  logic                   cfg_we,
   input  logic [1:0]             cfg_addr,
   input  logic [WIDTH-1:0]       cfg_data,
   input  logic                   rain,
   irrigation_scheduler_if.master ctrl,
   output logic [4:0]             hour,
   output logic                   busy,
   output logic                   skipped_rain,
   output logic                   start_fail,
   output logic [7:0]             cycle_count
);

   localparam int SEC_W  = (SEC_PER_HOUR > 1) ? $clog2(SEC_PER_HOUR) : 1;
   localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int WIN_HI = (START_HOUR + RETRY_HOURS > 23) ? 23 : START_HOUR + RETRY_HOURS;

   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_HOUR - 1);
   localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [ACK_W-1:0] ACK_ONE  = ACK_W'(1);
   localparam logic [1:0]       LAST_U   = 2'(NUM_USERS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_LOAD  = 3'd2,
      S_START = 3'd3,
      S_ACK   = 3'd4,
      S_RUN   = 3'd5
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [SEC_W-1:0] sec_r;
   logic [4:0]       hour_r;
   logic [1:0]       u_r;
   logic [1:0]       u_nx_s;
   logic [ACK_W-1:0] ack_r;
   logic [ACK_W-1:0] ack_nx_s;
   logic [WIDTH-1:0] shadow_r [NUM_USERS];

   logic             done_today_r;
   logic             mid_pend_r;
   logic             start_pend_r;
   logic             skipped_rain_r;
   logic             start_fail_r;
   logic [7:0]       cycle_count_r;
   logic             busy_r;

   logic             hour_tick_s;
   logic             set_ok_s;
   logic             tick_s;
   logic [4:0]       hour_next_s;
   logic             mid_evt_s;
   logic             start_evt_s;

   logic             clr_mid_s;
   logic             clr_start_s;
   logic             set_done_s;
   logic             set_skip_s;
   logic             clr_skip_s;
   logic             set_fail_s;
   logic             clr_fail_s;
   logic             inc_cnt_s;

   logic             acs_s;
   logic             rst_usr_s;
   logic             qwr_s;
   logic [1:0]       sel_s;
   logic [WIDTH-1:0] qset_s;

   // Hour rollover and the events it raises; a valid time load suppresses the tick.
   always_comb begin
      hour_tick_s = (sec_r == SEC_LAST);
      set_ok_s    = time_set && (time_hour < 5'd24);
      tick_s      = hour_tick_s && !set_ok_s;
      if (hour_r == 5'd23) begin
         hour_next_s = 5'd0;
      end else begin
         hour_next_s = hour_r + 5'd1;
      end
      mid_evt_s   = tick_s && (hour_next_s == 5'd0);
      // The midnight clear of done_today also applies when the window starts at hour 0.
      start_evt_s = tick_s
                    && (int'(hour_next_s) >= START_HOUR)
                    && (int'(hour_next_s) <= WIN_HI)
                    && (!done_today_r || mid_evt_s);
   end

   // Seconds and hour counters; a time load restarts the hour from its first second.
   always_ff @(posedge clk_1hz or negedge rst_n) begin
      if (!rst_n) begin
         sec_r  <= {SEC_W{1'b0}};
         hour_r <= 5'd0;
      end else if (set_ok_s) begin
         sec_r  <= {SEC_W{1'b0}};
         hour_r <= time_hour;
      end else if (hour_tick_s) begin
         sec_r  <= {SEC_W{1'b0}};
         hour_r <= hour_next_s;
      end else begin
         sec_r  <= sec_r + SEC_ONE;
      end
   end

   // Daily quota shadow registers, written from the configuration port.
   always_ff @(posedge clk_1hz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_USERS; i++) begin
            shadow_r[i] <= {WIDTH{1'b0}};
         end
      end else if (cfg_we && (int'(cfg_addr) < NUM_USERS)) begin
         shadow_r[cfg_addr] <= cfg_data;
      end
   end

   // Next-state decode plus the strobe values for the state being occupied.
   always_comb begin
      state_nx_s  = state_r;
      u_nx_s      = u_r;
      ack_nx_s    = ack_r;
      clr_mid_s   = 1'b0;
      clr_start_s = 1'b0;
      set_done_s  = 1'b0;
      set_skip_s  = 1'b0;
      clr_skip_s  = 1'b0;
      set_fail_s  = 1'b0;
      clr_fail_s  = 1'b0;
      inc_cnt_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (mid_pend_r && !ctrl.sequencer_active) begin
               state_nx_s = S_CLR;
               u_nx_s     = 2'd0;
               clr_mid_s  = 1'b1;
            end else if (start_pend_r && rain) begin
               clr_start_s = 1'b1;
               set_skip_s  = 1'b1;
            end else if (start_pend_r && ctrl.sequencer_active) begin
               clr_start_s = 1'b1;
               set_done_s  = 1'b1;
            end else if (start_pend_r) begin
               state_nx_s  = S_START;
               clr_start_s = 1'b1;
               set_done_s  = 1'b1;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_CLR: begin
            state_nx_s = S_LOAD;
         end
         S_LOAD: begin
            if (u_r == LAST_U) begin
               state_nx_s = S_IDLE;
            end else begin
               u_nx_s     = u_r + 2'd1;
               state_nx_s = S_CLR;
            end
         end
         S_START: begin
            state_nx_s = S_ACK;
            ack_nx_s   = {ACK_W{1'b0}};
         end
         S_ACK: begin
            if (ctrl.sequencer_active) begin
               state_nx_s = S_RUN;
               clr_fail_s = 1'b1;
               clr_skip_s = 1'b1;
            end else if (ack_r == ACK_LAST) begin
               state_nx_s = S_IDLE;
               set_fail_s = 1'b1;
            end else begin
               ack_nx_s = ack_r + ACK_ONE;
            end
         end
         S_RUN: begin
            if (!ctrl.sequencer_active) begin
               state_nx_s = S_IDLE;
               inc_cnt_s  = 1'b1;
            end else begin
               state_nx_s = S_RUN;
            end
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase

      acs_s     = (state_r == S_START);
      rst_usr_s = (state_r == S_CLR);
      qwr_s     = (state_r == S_LOAD);
      if ((state_r == S_CLR) || (state_r == S_LOAD)) begin
         sel_s = u_r;
      end else begin
         sel_s = 2'd0;
      end
      if (state_r == S_LOAD) begin
         qset_s = shadow_r[u_r];
      end else begin
         qset_s = {WIDTH{1'b0}};
      end
   end

   // FSM state, zone index and acknowledge counter.
   always_ff @(posedge clk_1hz or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         u_r     <= 2'd0;
         ack_r   <= {ACK_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         u_r     <= u_nx_s;
         ack_r   <= ack_nx_s;
      end
   end

   // Pending events, daily bookkeeping and sticky status; a new event beats a same-cycle clear.
   always_ff @(posedge clk_1hz or negedge rst_n) begin
      if (!rst_n) begin
         mid_pend_r     <= 1'b0;
         start_pend_r   <= 1'b0;
         done_today_r   <= 1'b0;
         skipped_rain_r <= 1'b0;
         start_fail_r   <= 1'b0;
         cycle_count_r  <= 8'd0;
         busy_r         <= 1'b0;
      end else begin
         mid_pend_r   <= mid_evt_s   || (mid_pend_r   && !clr_mid_s);
         start_pend_r <= start_evt_s || (start_pend_r && !clr_start_s);
         if (mid_evt_s) begin
            done_today_r <= 1'b0;
         end else if (set_done_s) begin
            done_today_r <= 1'b1;
         end else begin
            done_today_r <= done_today_r;
         end
         if (set_skip_s) begin
            skipped_rain_r <= 1'b1;
         end else if (clr_skip_s) begin
            skipped_rain_r <= 1'b0;
         end else begin
            skipped_rain_r <= skipped_rain_r;
         end
         if (set_fail_s) begin
            start_fail_r <= 1'b1;
         end else if (clr_fail_s) begin
            start_fail_r <= 1'b0;
         end else begin
            start_fail_r <= start_fail_r;
         end
         if (inc_cnt_s && (cycle_count_r != 8'd255)) begin
            cycle_count_r <= cycle_count_r + 8'd1;
         end else begin
            cycle_count_r <= cycle_count_r;
         end
         busy_r <= (state_nx_s != S_IDLE);
      end
   end

   // Controller strobes lag the state by one edge so each lasts exactly one period.
   always_ff @(posedge clk_1hz or negedge rst_n) begin
      if (!rst_n) begin
         ctrl.auto_cycle_start   <= 1'b0;
         ctrl.reset_user         <= 1'b0;
         ctrl.quota_wr           <= 1'b0;
         ctrl.user_select_manual <= 2'd0;
         ctrl.quota_set          <= {WIDTH{1'b0}};
      end else begin
         ctrl.auto_cycle_start   <= acs_s;
         ctrl.reset_user         <= rst_usr_s;
         ctrl.quota_wr           <= qwr_s;
         ctrl.user_select_manual <= sel_s;
         ctrl.quota_set          <= qset_s;
      end
   end

   assign hour         = hour_r;
   assign busy         = busy_r;
   assign skipped_rain = skipped_rain_r;
   assign start_fail   = start_fail_r;
   assign cycle_count  = cycle_count_r;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed-random bench for irrigation_scheduler with a scenario-level expectation model.
module tb_irrigation_scheduler;

   localparam int NU  = 4;
   localparam int W   = 6;
   localparam int SPH = 4;
   localparam int SH  = 6;
   localparam int RH  = 2;
   localparam int AT  = 2;

   logic         clk_1hz   = 1'b0;
   logic         rst_n     = 1'b1;
   logic         time_set  = 1'b0;
   logic [4:0]   time_hour = 5'd0;
   logic         cfg_we    = 1'b0;
   logic [1:0]   cfg_addr  = 2'd0;
   logic [W-1:0] cfg_data  = '0;
   logic         rain      = 1'b0;
   logic [4:0]   hour;
   logic         busy;
   logic         skipped_rain;
   logic         start_fail;
   logic [7:0]   cycle_count;

   irrigation_scheduler_if #(.WIDTH(W)) ctrl ();

   irrigation_scheduler #(
      .NUM_USERS(NU), .WIDTH(W), .SEC_PER_HOUR(SPH),
      .START_HOUR(SH), .RETRY_HOURS(RH), .ACK_TIMEOUT(AT)
   ) dut (
      .clk_1hz(clk_1hz), .rst_n(rst_n), .time_set(time_set), .time_hour(time_hour),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .rain(rain),
      .ctrl(ctrl), .hour(hour), .busy(busy), .skipped_rain(skipped_rain),
      .start_fail(start_fail), .cycle_count(cycle_count)
   );

   always #5 clk_1hz = ~clk_1hz;

   int n_vec       = 0;
   int n_err       = 0;
   int acs_seen    = 0;
   int strobe_seen = 0;
   int exp_cnt     = 0;
   int shadow_m [NU];

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_vec++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_1hz);
         acs_seen    += int'(ctrl.auto_cycle_start);
         strobe_seen += int'(ctrl.reset_user) + int'(ctrl.quota_wr);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      time_set = 1'b0; cfg_we = 1'b0; rain = 1'b0;
      ctrl.sequencer_active = 1'b0;
      step(2);
      rst_n = 1'b1;
      acs_seen = 0; strobe_seen = 0; exp_cnt = 0;
      for (int i = 0; i < NU; i++) shadow_m[i] = 0;
   endtask

   task automatic set_time(input int h);
      time_set = 1'b1;
      time_hour = 5'(h);
      step(1);
      time_set = 1'b0;
   endtask

   task automatic write_shadow(input int a, input int v);
      cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = W'(v);
      step(1);
      cfg_we = 1'b0;
      shadow_m[a] = v;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rst"},  int'(ctrl.reset_user), 0);
      chk({tag, "_qwr"},  int'(ctrl.quota_wr), 0);
      chk({tag, "_sel"},  int'(ctrl.user_select_manual), 0);
      chk({tag, "_qset"}, int'(ctrl.quota_set), 0);
   endtask

   // Called on the cycle where the scheduler sits in IDLE with a midnight job it can serve.
   task automatic midnight_check(input bit late);
      int nv;
      step(1);
      chk("mid_busy", int'(busy), 1);
      chk_quiet("mid_pre");
      for (int i = 0; i < 2 * NU; i++) begin
         step(1);
         if (i == 2) cfg_we = 1'b0;
         chk("mid_rst",  int'(ctrl.reset_user), (i % 2 == 0) ? 1 : 0);
         chk("mid_qwr",  int'(ctrl.quota_wr),   i % 2);
         chk("mid_sel",  int'(ctrl.user_select_manual), i / 2);
         chk("mid_qset", int'(ctrl.quota_set), (i % 2 == 1) ? shadow_m[i / 2] : 0);
         if (late && i == 1) begin
            nv = int'($urandom_range(0, 63));
            cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = W'(nv);
            shadow_m[3] = nv;
         end
      end
      cfg_we = 1'b0;
      step(1);
      chk_quiet("mid_post");
      chk("mid_done_busy", int'(busy), 0);
   endtask

   // Called on the cycle where auto_cycle_start should be visible.
   task automatic start_and_run(input int d, input int len);
      chk("start_pulse", int'(ctrl.auto_cycle_start), 1);
      if (d == 1) begin
         step(1);
         chk("start_width", int'(ctrl.auto_cycle_start), 0);
      end
      ctrl.sequencer_active = 1'b1;
      step(1);
      chk("ack_acs_low", int'(ctrl.auto_cycle_start), 0);
      chk("ack_skip_clr", int'(skipped_rain), 0);
      chk("ack_fail_clr", int'(start_fail), 0);
      chk("run_busy", int'(busy), 1);
      step(len - 1);
      chk("run_busy_end", int'(busy), 1);
      ctrl.sequencer_active = 1'b0;
      step(1);
      exp_cnt++;
      chk("run_count", int'(cycle_count), exp_cnt);
      chk("run_idle", int'(busy), 0);
   endtask

   // stop_k: hours after START_HOUR at which rain stops (3 = never inside the window).
   task automatic rain_run(input int stop_k);
      bit started;
      started = 1'b0;
      do_reset();
      rain = 1'b1;
      set_time(SH - 1);
      step(5);
      chk("rain_skip_set", int'(skipped_rain), 1);
      chk("rain_idle", int'(busy), 0);
      for (int k = 1; k <= RH; k++) begin
         if (!started) begin
            step(2);
            if (k == stop_k) rain = 1'b0;
            step(2);
            if (k < stop_k) begin
               chk("rain_hold_skip", int'(skipped_rain), 1);
               chk("rain_hold_idle", int'(busy), 0);
            end else begin
               chk("retry_busy", int'(busy), 1);
               step(1);
               chk("retry_skip_before_ack", int'(skipped_rain), 1);
               start_and_run(int'($urandom_range(0, 1)), int'($urandom_range(4, 15)));
               started = 1'b1;
            end
         end
      end
      rain = 1'b0;
      step(12);
      chk("rain_starts", acs_seen, (stop_k <= RH) ? 1 : 0);
      chk("rain_skip_final", int'(skipped_rain), (stop_k <= RH) ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ctrl.sequencer_active = 1'b0;
      #2;
      do_reset();
      chk("rst_acs", int'(ctrl.auto_cycle_start), 0);
      chk_quiet("rst");
      chk("rst_hour", int'(hour), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_skip", int'(skipped_rain), 0);
      chk("rst_fail", int'(start_fail), 0);
      chk("rst_count", int'(cycle_count), 0);

      // Midnight reload with random shadow contents.
      for (int rep = 0; rep < 2; rep++) begin
         do_reset();
         for (int z = 0; z < NU; z++) write_shadow(z, int'($urandom_range(0, 63)));
         set_time(23);
         step(3);
         chk("pre_midnight_hour", int'(hour), 23);
         step(1);
         chk("midnight_hour", int'(hour), 0);
         midnight_check(rep == 1);
      end

      // Normal start at START_HOUR.
      do_reset();
      set_time(SH - 1);
      step(4);
      chk("start_hour", int'(hour), SH);
      step(1);
      chk("start_busy", int'(busy), 1);
      chk("start_not_yet", int'(ctrl.auto_cycle_start), 0);
      step(1);
      start_and_run(int'($urandom_range(0, 1)), 20);
      step(16);
      chk("normal_single_start", acs_seen, 1);
      chk("normal_fail", int'(start_fail), 0);

      // Rain retries: never-clearing rain first, then random retry hours.
      rain_run(3);
      rain_run(int'($urandom_range(1, 2)));
      rain_run(int'($urandom_range(1, 2)));

      // No acknowledge.
      do_reset();
      set_time(SH - 1);
      step(6);
      chk("noack_pulse", int'(ctrl.auto_cycle_start), 1);
      step(AT - 1);
      chk("noack_fail_early", int'(start_fail), 0);
      chk("noack_busy", int'(busy), 1);
      step(1);
      chk("noack_fail", int'(start_fail), 1);
      chk("noack_idle", int'(busy), 0);
      step(12);
      chk("noack_single_start", acs_seen, 1);

      // Midnight deferred behind a running cycle; time load collides with an hour tick.
      do_reset();
      for (int z = 0; z < NU; z++) write_shadow(z, int'($urandom_range(0, 63)));
      set_time(SH - 1);
      step(6);
      chk("defer_start", int'(ctrl.auto_cycle_start), 1);
      ctrl.sequencer_active = 1'b1;
      step(1);
      set_time(23);
      chk("set_beats_tick", int'(hour), 23);
      strobe_seen = 0;
      step(4);
      chk("defer_hour", int'(hour), 0);
      step(int'($urandom_range(2, 9)));
      chk("defer_no_strobes", strobe_seen, 0);
      chk("defer_busy", int'(busy), 1);
      ctrl.sequencer_active = 1'b0;
      step(1);
      exp_cnt++;
      chk("defer_count", int'(cycle_count), exp_cnt);
      chk("defer_idle", int'(busy), 0);
      midnight_check(1'b0);

      // Reset during LOAD of zone 1.
      do_reset();
      for (int z = 0; z < NU; z++) write_shadow(z, int'($urandom_range(1, 63)));
      set_time(23);
      step(4);
      step(5);
      chk("abort_in_load", int'(ctrl.quota_wr), 1);
      chk("abort_zone", int'(ctrl.user_select_manual), 1);
      rst_n = 1'b0;
      #1;
      chk_quiet("abort");
      chk("abort_acs", int'(ctrl.auto_cycle_start), 0);
      chk("abort_hour", int'(hour), 0);
      chk("abort_busy", int'(busy), 0);
      step(2);
      rst_n = 1'b1;
      strobe_seen = 0;
      acs_seen = 0;
      step(20);
      chk("abort_no_resume", strobe_seen, 0);
      chk("abort_no_start", acs_seen, 0);
      chk("abort_hour_count", int'(hour), 5);
      set_time(30);
      chk("bad_hour_ignored", int'(hour), 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
